keccak_arbiter: RTL
===================

// Module: keccak_arbiter
// PURPOSE
//  Shares one keccak core between N_REQ requesters (matrix-gen SHAKE128, PRF SHAKE256, G/H SHA3).
//  Grants one job at a time and latches its mode/lengths onto the core config ports.
//  Routes the granted requester's input words to the core and the core's output words back to it.
//  Counts output words to detect the end of the job.
// PARAMETERS
//  N_REQ     4   number of requesters (>=2)
//  BW_CTRL   2   keccak mode width (00 SHAKE128, 01 SHAKE256, 10 SHA3-256, 11 SHA3-512)
//  COOL_CYC  2   idle cycles inserted after each job before the next grant (core return-to-idle)
// PORTS
//  i_clk            in   1          clock
//  i_rstn           in   1          async active-low reset
//  i_req            in   N_REQ      per-requester job request, level, held until o_done
//  i_req_mode       in   N_REQ*2    packed mode, slice k = [k*2+:2]
//  i_req_ibyte_len  in   N_REQ*11   packed input length in bytes
//  i_req_obyte_len  in   N_REQ*10   packed output length in bytes (SHAKE only)
//  i_req_bytes      in   N_REQ*64   packed input words
//  i_req_bytes_vld  in   N_REQ      per-requester input word valid
//  o_gnt            out  N_REQ      one-hot grant, high for whole job
//  o_rsp_bytes      out  64         output word (broadcast)
//  o_rsp_vld        out  N_REQ      output word valid, only the granted bit
//  o_done           out  N_REQ      1-cycle pulse on the granted bit when its job ends
//  o_busy           out  1          high in any state except IDLE
//  o_kc_mode        out  2          to core i_mode
//  o_kc_ibyte_len   out  11         to core i_ibyte_len
//  o_kc_obyte_len   out  10         to core i_obyte_len
//  o_kc_bytes       out  64         to core i_bytes
//  o_kc_bytes_vld   out  1          to core i_bytes_valid
//  i_kc_bytes       in   64         from core o_bytes
//  i_kc_bytes_vld   in   1          from core o_bytes_valid
// BEHAVIOUR
//  Reset: every output is 0, FSM=IDLE, word counter=0, RR pointer=0.
//  FSM: IDLE -> (|i_req) GRANT -> ACTIVE -> (last word) DONE -> COOL -> (COOL_CYC cycles) IDLE.
//  GRANT (1 cycle): winner is picked and registered into o_gnt.
//   mode/ilen/olen are latched into o_kc_* registers and stay stable until IDLE.
//  Target word count, 8b: SHAKE = max(1,(olen+7)>>3); SHA3-256 = 4; SHA3-512 = 8.
//  ACTIVE: o_kc_bytes / o_kc_bytes_vld combinationally mux the granted slice (0 latency).
//   Non-granted i_req_bytes_vld are ignored.
//   o_rsp_bytes = i_kc_bytes and o_rsp_vld = o_gnt & {N{i_kc_bytes_vld}}, both combinational.
//   The counter increments on each i_kc_bytes_vld. When the valid that brings cnt+1 == target
//   arrives, go to DONE. Any i_kc_bytes_vld outside ACTIVE is dropped.
//  DONE (1 cycle): o_done = o_gnt, o_gnt stays high. On exit o_gnt <= 0 and the counter clears.
//  COOL: o_kc_bytes_vld forced 0 for COOL_CYC cycles. Requests are sampled again only in IDLE.
//  A request dropped mid-job is ignored: the job runs to completion and o_done still pulses.
//  A request that stays high after o_done is a new job and may be re-granted.
//  Async reset mid-job returns everything to reset values; the core is reset by the same i_rstn.
//  o_gnt is never multi-hot. A new grant never occurs while busy.
// CONFIGURATION
//  KECCAK_ARB_RR_EN defined: round-robin. Search starts at (last granted index + 1) mod N_REQ;
//   the pointer updates in GRANT.
//  Not defined: fixed priority, lowest index wins, no pointer register.
// TESTING
//  Single req1 SHA3-256, ilen=32 -> o_gnt=0010; exactly 4 o_rsp_vld[1]; o_done[1] on cycle after 4th.
//  req0 SHAKE128 olen=168 -> 21 words routed; olen=0 -> 1 word, then done.
//  req0+req2 asserted together, fixed prio -> 0 first then 2; with RR after 0 and req0 held -> 2 next.
//  Non-granted i_req_bytes_vld toggling during a job -> o_kc_bytes_vld follows only the granted bit.
//  Stray i_kc_bytes_vld in IDLE/COOL -> no o_rsp_vld, counter stays 0.
//  i_rstn low mid-ACTIVE (after 3 of 8 words) -> all outputs 0; re-request completes 8 words cleanly.

Source files
------------

// File: rtl/keccak_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// keccak_arbiter : shares one keccak core between N_REQ requesters
//   (grant, config latch, data routing, end-of-job detection).
//   Define KECCAK_ARB_RR_EN for round-robin; default is fixed lowest-index.
// Revision : 1.0
// ============================================================================
module keccak_arbiter #(
  parameter int N_REQ    = 4,
  parameter int BW_CTRL  = 2,
  parameter int COOL_CYC = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*BW_CTRL-1:0] i_req_mode,
  input  logic [N_REQ*11-1:0]    i_req_ibyte_len,
  input  logic [N_REQ*10-1:0]    i_req_obyte_len,
  input  logic [N_REQ*64-1:0]    i_req_bytes,
  input  logic [N_REQ-1:0]       i_req_bytes_vld,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [63:0]            o_rsp_bytes,
  output logic [N_REQ-1:0]       o_rsp_vld,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy,
  output logic [BW_CTRL-1:0]     o_kc_mode,
  output logic [10:0]            o_kc_ibyte_len,
  output logic [9:0]             o_kc_obyte_len,
  output logic [63:0]            o_kc_bytes,
  output logic                   o_kc_bytes_vld,
  input  logic [63:0]            i_kc_bytes,
  input  logic                   i_kc_bytes_vld
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
  localparam logic [CW-1:0] COOL_LAST = CW'((COOL_CYC > 0) ? COOL_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_ACTIVE = 3'd2,
    S_DONE   = 3'd3,
    S_COOL   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW_CTRL-1:0]  mode_q, mode_d;
  logic [10:0]         ilen_q, ilen_d;
  logic [9:0]          olen_q, olen_d;
  logic [7:0]          tgt_q, tgt_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CW-1:0]       cool_q, cool_d;

  logic                win_found;
  logic [IW-1:0]       win_idx;
  logic [BW_CTRL-1:0]  win_mode;
  logic [10:0]         win_ilen;
  logic [9:0]          win_olen;
  logic [7:0]          win_ceil;
  logic [7:0]          win_tgt;
  logic                active;

`ifdef KECCAK_ARB_RR_EN
  logic [IW-1:0]       ptr_q, ptr_d;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && i_req[(int'(ptr_q) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end
`else
  always_comb begin
    win_found = |i_req;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) win_idx = IW'(k);
    end
  end
`endif

  assign win_mode = i_req_mode[win_idx*BW_CTRL +: BW_CTRL];
  assign win_ilen = i_req_ibyte_len[win_idx*11 +: 11];
  assign win_olen = i_req_obyte_len[win_idx*10 +: 10];
  // olen <= 1023 bytes keeps the word count within 8 bits (max 128)
  assign win_ceil = 8'((11'(win_olen) + 11'd7) >> 3);

  always_comb begin
    if (win_mode[1])              win_tgt = win_mode[0] ? 8'd8 : 8'd4;
    else if (win_ceil == 8'd0)    win_tgt = 8'd1;
    else                          win_tgt = win_ceil;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    ilen_d  = ilen_q;
    olen_d  = olen_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    cool_d  = cool_q;
`ifdef KECCAK_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          gnt_d   = N_REQ'(1) << win_idx;
          idx_d   = win_idx;
          mode_d  = win_mode;
          ilen_d  = win_ilen;
          olen_d  = win_olen;
          tgt_d   = win_tgt;
        end
      end
      S_GRANT: begin
        state_d = S_ACTIVE;
`ifdef KECCAK_ARB_RR_EN
        ptr_d   = (int'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
`endif
      end
      S_ACTIVE: begin
        if (i_kc_bytes_vld) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == tgt_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d  = '0;
        cnt_d  = '0;
        cool_d = '0;
        if (COOL_CYC == 0) begin
          state_d = S_IDLE;
          mode_d  = '0;
          ilen_d  = '0;
          olen_d  = '0;
          tgt_d   = '0;
        end else begin
          state_d = S_COOL;
        end
      end
      S_COOL: begin
        if (cool_q == COOL_LAST) begin
          state_d = S_IDLE;
          mode_d  = '0;
          ilen_d  = '0;
          olen_d  = '0;
          tgt_d   = '0;
        end else begin
          cool_d = cool_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      ilen_q  <= '0;
      olen_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      cool_q  <= '0;
`ifdef KECCAK_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      ilen_q  <= ilen_d;
      olen_q  <= olen_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      cool_q  <= cool_d;
`ifdef KECCAK_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Data paths are open only while ACTIVE; stray core valids elsewhere are dropped
  assign active         = (state_q == S_ACTIVE);
  assign o_gnt          = gnt_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE) ? gnt_q : '0;
  assign o_kc_mode      = mode_q;
  assign o_kc_ibyte_len = ilen_q;
  assign o_kc_obyte_len = olen_q;
  assign o_kc_bytes     = active ? i_req_bytes[idx_q*64 +: 64] : '0;
  assign o_kc_bytes_vld = active & i_req_bytes_vld[idx_q];
  assign o_rsp_bytes    = active ? i_kc_bytes : '0;
  assign o_rsp_vld      = active ? (gnt_q & {N_REQ{i_kc_bytes_vld}}) : '0;

endmodule
`default_nettype wire
